// File: rtl/step_ctrl_if.sv
// Datapath-side bus of the step controller: load/clear/function controls out,
// current shift register value back.
interface step_ctrl_if;
  logic [7:0] pos;
  logic       cl;
  logic       ld;
  logic [1:0] funcc;
  logic       sel;
  logic       seed;

  modport master (input pos, output cl, ld, funcc, sel, seed);
  modport slave  (output pos, input cl, ld, funcc, sel, seed);
endinterface

// File: rtl/step_ctrl.sv
// Running-light controller: synchronised/debounced pushbutton, step tick
// divider and IDLE/SEED/RUN/PAUSE sequencer driving an external shift register.
module step_ctrl #(
  parameter int TICK_DIV  = 1000,
  parameter int DB_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_n,
  input  logic          dir_sw,
  input  logic          mode_sw,
  step_ctrl_if.master   dp,
  output logic          running
);

  localparam logic [15:0] TICK_LOAD = 16'(TICK_DIV - 1);
  localparam logic [7:0]  DB_LAST   = 8'(DB_CYCLES - 1);
  localparam logic [1:0]  FN_HOLD   = 2'b00;
  localparam logic [1:0]  FN_LEFT   = 2'b01;
  localparam logic [1:0]  FN_RIGHT  = 2'b10;

  typedef enum logic [1:0] {IDLE, SEED, RUN, PAUSE} state_t;

  // Bit 0 key_n, bit 1 dir_sw, bit 2 mode_sw; all idle high in reset.
  logic [2:0] async_in;
  logic [2:0] sync1_reg;
  logic [2:0] sync2_reg;

  assign async_in = {mode_sw, dir_sw, key_n};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg[gi] <= 1'b1;
          sync2_reg[gi] <= 1'b1;
        end else begin
          sync1_reg[gi] <= async_in[gi];
          sync2_reg[gi] <= sync1_reg[gi];
        end
      end
    end
  endgenerate

  logic key_sync;
  logic dir_sync;
  logic mode_sync;

  assign key_sync  = sync2_reg[0];
  assign dir_sync  = sync2_reg[1];
  assign mode_sync = sync2_reg[2];

  // Debounce: the accepted level flips on the DB_CYCLES-th consecutive
  // differing sample; press marks that flip when it goes high-to-low.
  logic       db_level_reg;
  logic [7:0] db_cnt_reg;
  logic       db_differ;
  logic       db_flip;
  logic       press;

  assign db_differ = (key_sync != db_level_reg);
  assign db_flip   = db_differ && (db_cnt_reg == DB_LAST);
  assign press     = db_flip && db_level_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_level_reg <= 1'b1;
      db_cnt_reg   <= '0;
    end else if (db_flip) begin
      db_level_reg <= key_sync;
      db_cnt_reg   <= '0;
    end else if (db_differ) begin
      db_cnt_reg   <= db_cnt_reg + 8'd1;
    end else begin
      db_cnt_reg   <= '0;
    end
  end

  logic [15:0] tick_cnt_reg;
  logic        tick;

  assign tick = (tick_cnt_reg == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tick_cnt_reg <= TICK_LOAD;
    else if (tick)
      tick_cnt_reg <= TICK_LOAD;
    else
      tick_cnt_reg <= tick_cnt_reg - 16'd1;
  end

  state_t state_reg, state_next;
  logic   dir_q_reg, dir_q_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      dir_q_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      dir_q_reg <= dir_q_next;
    end
  end

  // Wrap follows the switch each tick; bounce keeps dir_q and turns at the ends.
  logic dir_base;
  logic at_end;
  logic dir_turn;

  assign dir_base = mode_sync ? dir_q_reg : dir_sync;
  assign at_end   = mode_sync && ((!dir_q_reg && dp.pos == 8'h80) ||
                                  ( dir_q_reg && dp.pos == 8'h01));
  assign dir_turn = dir_base ^ at_end;

  always_comb begin
    state_next = state_reg;
    dir_q_next = dir_q_reg;
    dp.cl      = 1'b0;
    dp.ld      = 1'b0;
    dp.funcc   = FN_HOLD;
    dp.sel     = 1'b0;
    dp.seed    = 1'b0;
    running    = 1'b0;
    case (state_reg)
      IDLE: begin
        dp.cl = 1'b1;
        if (tick)
          state_next = SEED;
      end
      SEED: begin
        if (tick) begin
          dp.ld      = 1'b1;
          dp.seed    = 1'b1;
          dp.sel     = ~dir_sync;
          dir_q_next = dir_sync;
          state_next = RUN;
        end
      end
      RUN: begin
        running = 1'b1;
        if (tick) begin
          dp.ld = 1'b1;
          if (dp.pos == 8'h00) begin
            // Pattern shifted out: restart from the seed at the trailing end.
            dp.seed    = 1'b1;
            dp.sel     = ~dir_base;
            dir_q_next = dir_base;
          end else begin
            dir_q_next = dir_turn;
            dp.funcc   = dir_turn ? FN_RIGHT : FN_LEFT;
          end
        end
        if (press)
          state_next = PAUSE;
      end
      PAUSE: begin
        if (press)
          state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
